// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for the register-file write-port arbiter: pipeline writeback,
// long-latency result handshake, register-file write port and hazard-unit feedback.
interface wb_port_arbiter_if;
  logic        pipe_we_w;
  logic [4:0]  pipe_rd_w;
  logic [31:0] pipe_wd_w;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_wd;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        bubble_req;
  logic [1:0]  pend_valid;
  logic [4:0]  pend_rd0;
  logic [4:0]  pend_rd1;

  // Arbiter side.
  modport slave (
    input  pipe_we_w, pipe_rd_w, pipe_wd_w, lu_valid, lu_rd, lu_wd,
    output lu_ready, rf_we, rf_rd, rf_wd, bubble_req, pend_valid, pend_rd0, pend_rd1
  );

  // Pipeline / long-latency unit side.
  modport master (
    output pipe_we_w, pipe_rd_w, pipe_wd_w, lu_valid, lu_rd, lu_wd,
    input  lu_ready, rf_we, rf_rd, rf_wd, bubble_req, pend_valid, pend_rd0, pend_rd1
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. The pipeline writeback always wins the
// port; long-latency results either bypass straight to the port or wait in a
// 2-entry in-order buffer. Buffered entries made stale by a younger pipeline
// write to the same register are killed (written never). A starvation counter
// asks the hazard unit for a writeback bubble when the head waits too long.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              reset,
  wb_port_arbiter_if.slave bus
);

  localparam logic [2:0] LIMIT_C = 3'(STARVE_LIMIT);

  logic [1:0]       count_q, count_d;
  logic [1:0][4:0]  rd_q, rd_d;
  logic [1:0][31:0] data_q, data_d;
  logic [1:0]       live_q, live_d;
  logic [2:0]       starve_q, starve_d;
  logic             bubble_q, bubble_d;

  logic       pipe_write_s;
  logic       port_free_s;
  logic       lu_ready_s;
  logic       xfer_s;
  logic       lu_nz_s;
  logic       pop_s;
  logic       bypass_s;
  logic       push_kill_s;
  logic       push_s;
  logic [1:0] count_pop_s;
  logic [1:0] pend_valid_s;

  // Port request decode; everything is squashed while reset is high.
  always_comb begin
    pipe_write_s = !reset && bus.pipe_we_w && (bus.pipe_rd_w != 5'd0);
    port_free_s  = !pipe_write_s;
    lu_ready_s   = (count_q < 2'd2);
    xfer_s       = !reset && bus.lu_valid && lu_ready_s;
    lu_nz_s      = (bus.lu_rd != 5'd0);
    pop_s        = !reset && port_free_s && (count_q != 2'd0);
    bypass_s     = xfer_s && lu_nz_s && (count_q == 2'd0) && port_free_s;
    push_kill_s  = pipe_write_s && (bus.lu_rd == bus.pipe_rd_w);
    push_s       = xfer_s && lu_nz_s && !bypass_s && !push_kill_s;
    count_pop_s  = pop_s ? (count_q - 2'd1) : count_q;
  end

  // Write-port mux: pipeline > live buffer head > direct bypass. A dead head pops silently.
  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_rd = 5'd0;
    bus.rf_wd = 32'd0;
    if (pipe_write_s) begin
      bus.rf_we = 1'b1;
      bus.rf_rd = bus.pipe_rd_w;
      bus.rf_wd = bus.pipe_wd_w;
    end else if (pop_s && live_q[0]) begin
      bus.rf_we = 1'b1;
      bus.rf_rd = rd_q[0];
      bus.rf_wd = data_q[0];
    end else if (bypass_s) begin
      bus.rf_we = 1'b1;
      bus.rf_rd = bus.lu_rd;
      bus.rf_wd = bus.lu_wd;
    end else begin
      bus.rf_we = 1'b0;
    end
  end

  // Buffer next state: kill WAW-shadowed entries, shift on pop, append at tail on push.
  always_comb begin
    rd_d      = rd_q;
    data_d    = data_q;
    live_d[0] = live_q[0] && !(pipe_write_s && (rd_q[0] == bus.pipe_rd_w));
    live_d[1] = live_q[1] && !(pipe_write_s && (rd_q[1] == bus.pipe_rd_w));
    count_d   = count_pop_s;
    if (pop_s) begin
      rd_d[0]   = rd_q[1];
      data_d[0] = data_q[1];
      live_d[0] = live_d[1];
      live_d[1] = 1'b0;
    end else begin
      live_d[1] = live_d[1];
    end
    if (push_s) begin
      if (count_pop_s == 2'd0) begin
        rd_d[0]   = bus.lu_rd;
        data_d[0] = bus.lu_wd;
        live_d[0] = 1'b1;
      end else begin
        rd_d[1]   = bus.lu_rd;
        data_d[1] = bus.lu_wd;
        live_d[1] = 1'b1;
      end
      count_d = count_pop_s + 2'd1;
    end else begin
      count_d = count_pop_s;
    end
  end

  // Starvation tracking: count cycles the head waits, then request a bubble until it drains.
  always_comb begin
    if ((count_q == 2'd0) || pop_s) begin
      starve_d = 3'd0;
    end else if (starve_q >= LIMIT_C) begin
      starve_d = LIMIT_C;
    end else begin
      starve_d = starve_q + 3'd1;
    end
    if (pop_s || (count_q == 2'd0)) begin
      bubble_d = 1'b0;
    end else if (starve_q == LIMIT_C) begin
      bubble_d = 1'b1;
    end else begin
      bubble_d = bubble_q;
    end
  end

  // State registers; reset drops buffered results without writing them.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 2'd0;
      rd_q     <= '0;
      data_q   <= '0;
      live_q   <= 2'b00;
      starve_q <= 3'd0;
      bubble_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      live_q   <= live_d;
      starve_q <= starve_d;
      bubble_q <= bubble_d;
    end
  end

  // Hazard-visible view of the buffer; fields are zero for absent or dead entries.
  always_comb begin
    pend_valid_s[0] = live_q[0] && (count_q != 2'd0);
    pend_valid_s[1] = live_q[1] && (count_q == 2'd2);
    bus.pend_valid  = pend_valid_s;
    bus.pend_rd0    = pend_valid_s[0] ? rd_q[0] : 5'd0;
    bus.pend_rd1    = pend_valid_s[1] ? rd_q[1] : 5'd0;
    bus.lu_ready    = lu_ready_s;
    bus.bubble_req  = bubble_q;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter. Every register-file write the
// design should perform is queued with the cycle it must appear in; a monitor
// pops and compares on each falling edge, and flags missing or extra writes.
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] wd;
  } wr_t;
  wr_t sb[$];

  wb_port_arbiter_if bus_if();
  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (.clk(clk), .reset(reset), .bus(bus_if));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: compare every observed write against the queued expectation.
  always @(negedge clk) begin : mon
    wr_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      total++; bad++;
      $display("FAIL missed_write cyc=%0d got=none exp=rd%0d:%h", e.cyc, e.rd, e.wd);
    end
    if (bus_if.rf_we === 1'b1) begin
      total++;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        if (bus_if.rf_rd !== e.rd || bus_if.rf_wd !== e.wd) begin
          bad++;
          $display("FAIL write_data cyc=%0d got=rd%0d:%h exp=rd%0d:%h", cyc, bus_if.rf_rd, bus_if.rf_wd, e.rd, e.wd);
        end
      end else begin
        bad++;
        $display("FAIL unexpected_write cyc=%0d got=rd%0d:%h exp=none", cyc, bus_if.rf_rd, bus_if.rf_wd);
      end
    end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      total++; bad++;
      $display("FAIL missed_write cyc=%0d got=none exp=rd%0d:%h", cyc, e.rd, e.wd);
    end
  end

  task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pwd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] lwd);
    bus_if.pipe_we_w = pwe; bus_if.pipe_rd_w = prd; bus_if.pipe_wd_w = pwd;
    bus_if.lu_valid  = lv;  bus_if.lu_rd     = lrd; bus_if.lu_wd     = lwd;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] wd);
    wr_t e;
    e.cyc = cyc; e.rd = rd; e.wd = wd;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 5'd3, 32'hAAAA_AAAA, 1'b1, 5'd5, 32'h5555_5555);
    @(negedge clk);
    total++; if (bus_if.rf_we !== 1'b0) begin bad++; $display("FAIL rst_rf_we got=%b exp=0", bus_if.rf_we); end
    tick(); tick();
    reset = 1'b0;
    idle();
    @(negedge clk);
    total++; if (bus_if.lu_ready !== 1'b1) begin bad++; $display("FAIL rst_lu_ready got=%b exp=1", bus_if.lu_ready); end
    total++; if (bus_if.pend_valid !== 2'b00) begin bad++; $display("FAIL rst_pend_valid got=%b exp=00", bus_if.pend_valid); end
    total++; if (bus_if.pend_rd0 !== 5'd0 || bus_if.pend_rd1 !== 5'd0) begin bad++; $display("FAIL rst_pend_rd got=%0d/%0d exp=0/0", bus_if.pend_rd0, bus_if.pend_rd1); end
    total++; if (bus_if.bubble_req !== 1'b0) begin bad++; $display("FAIL rst_bubble got=%b exp=0", bus_if.bubble_req); end
    total++; if (bus_if.rf_we !== 1'b0) begin bad++; $display("FAIL rst_idle_we got=%b exp=0", bus_if.rf_we); end
    tick();
  endtask

  task automatic test_bypass();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    expect_wr(5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    total++; if (bus_if.lu_ready !== 1'b1) begin bad++; $display("FAIL byp_ready got=%b exp=1", bus_if.lu_ready); end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 32'h1234_5678);
    expect_wr(5'd31, 32'h1234_5678);
    @(negedge clk);
    total++; if (bus_if.pend_valid !== 2'b00) begin bad++; $display("FAIL byp_count got=%b exp=00", bus_if.pend_valid); end
    tick();
    idle();
    @(negedge clk);
    total++; if (bus_if.lu_ready !== 1'b1 || bus_if.pend_valid !== 2'b00) begin bad++; $display("FAIL byp_after got=%b/%b exp=1/00", bus_if.lu_ready, bus_if.pend_valid); end
    tick();
  endtask

  task automatic test_contention();
    drive(1'b1, 5'd3, 32'hA0, 1'b1, 5'd7, 32'h70); expect_wr(5'd3, 32'hA0);
    @(negedge clk);
    total++; if (bus_if.lu_ready !== 1'b1) begin bad++; $display("FAIL ctn_ready0 got=%b exp=1", bus_if.lu_ready); end
    tick();
    drive(1'b1, 5'd3, 32'hA1, 1'b1, 5'd8, 32'h80); expect_wr(5'd3, 32'hA1);
    @(negedge clk);
    total++; if (bus_if.pend_valid !== 2'b01 || bus_if.pend_rd0 !== 5'd7) begin bad++; $display("FAIL ctn_one got=%b/%0d exp=01/7", bus_if.pend_valid, bus_if.pend_rd0); end
    total++; if (bus_if.lu_ready !== 1'b1) begin bad++; $display("FAIL ctn_ready1 got=%b exp=1", bus_if.lu_ready); end
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 5'd3, 32'hA2 + 32'(k), 1'b1, 5'd9, 32'h90); expect_wr(5'd3, 32'hA2 + 32'(k));
      @(negedge clk);
      total++; if (bus_if.lu_ready !== 1'b0) begin bad++; $display("FAIL ctn_stall got=%b exp=0", bus_if.lu_ready); end
      total++; if (bus_if.pend_valid !== 2'b11 || bus_if.pend_rd0 !== 5'd7 || bus_if.pend_rd1 !== 5'd8) begin bad++; $display("FAIL ctn_full got=%b/%0d/%0d exp=11/7/8", bus_if.pend_valid, bus_if.pend_rd0, bus_if.pend_rd1); end
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h90); expect_wr(5'd7, 32'h70);
    @(negedge clk);
    total++; if (bus_if.lu_ready !== 1'b0) begin bad++; $display("FAIL ctn_popfull got=%b exp=0", bus_if.lu_ready); end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h90); expect_wr(5'd8, 32'h80);
    @(negedge clk);
    total++; if (bus_if.lu_ready !== 1'b1 || bus_if.pend_rd0 !== 5'd8) begin bad++; $display("FAIL ctn_pushpop got=%b/%0d exp=1/8", bus_if.lu_ready, bus_if.pend_rd0); end
    tick();
    idle(); expect_wr(5'd9, 32'h90);
    @(negedge clk);
    total++; if (bus_if.pend_valid !== 2'b01 || bus_if.pend_rd0 !== 5'd9) begin bad++; $display("FAIL ctn_newhead got=%b/%0d exp=01/9", bus_if.pend_valid, bus_if.pend_rd0); end
    tick();
    idle();
    @(negedge clk);
    total++; if (bus_if.pend_valid !== 2'b00 || bus_if.lu_ready !== 1'b1) begin bad++; $display("FAIL ctn_drained got=%b/%b exp=00/1", bus_if.pend_valid, bus_if.lu_ready); end
    tick();
  endtask

  task automatic test_starvation();
    logic exp_b;
    drive(1'b1, 5'd3, 32'hB0, 1'b1, 5'd7, 32'h77); expect_wr(5'd3, 32'hB0);
    @(negedge clk);
    tick();
    for (int k = 1; k <= 7; k++) begin
      drive(1'b1, 5'd3, 32'hB0 + 32'(k), 1'b0, 5'd0, 32'd0); expect_wr(5'd3, 32'hB0 + 32'(k));
      exp_b = (k >= 6) ? 1'b1 : 1'b0;
      @(negedge clk);
      total++; if (bus_if.bubble_req !== exp_b) begin bad++; $display("FAIL stv_bubble k=%0d got=%b exp=%b", k, bus_if.bubble_req, exp_b); end
      total++; if (bus_if.pend_rd0 !== 5'd7) begin bad++; $display("FAIL stv_head k=%0d got=%0d exp=7", k, bus_if.pend_rd0); end
      tick();
    end
    idle(); expect_wr(5'd7, 32'h77);
    @(negedge clk);
    total++; if (bus_if.bubble_req !== 1'b1) begin bad++; $display("FAIL stv_popcyc got=%b exp=1", bus_if.bubble_req); end
    tick();
    idle();
    @(negedge clk);
    total++; if (bus_if.bubble_req !== 1'b0 || bus_if.pend_valid !== 2'b00) begin bad++; $display("FAIL stv_clear got=%b/%b exp=0/00", bus_if.bubble_req, bus_if.pend_valid); end
    tick();
  endtask

  task automatic test_waw();
    drive(1'b1, 5'd3, 32'hC0, 1'b1, 5'd9, 32'h11); expect_wr(5'd3, 32'hC0);
    @(negedge clk);
    tick();
    drive(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'd0); expect_wr(5'd9, 32'h22);
    @(negedge clk);
    total++; if (bus_if.pend_valid !== 2'b01 || bus_if.pend_rd0 !== 5'd9) begin bad++; $display("FAIL waw_before got=%b/%0d exp=01/9", bus_if.pend_valid, bus_if.pend_rd0); end
    tick();
    idle();
    @(negedge clk);
    total++; if (bus_if.pend_valid !== 2'b00 || bus_if.pend_rd0 !== 5'd0) begin bad++; $display("FAIL waw_killed got=%b/%0d exp=00/0", bus_if.pend_valid, bus_if.pend_rd0); end
    tick();
    idle();
    @(negedge clk);
    total++; if (bus_if.lu_ready !== 1'b1) begin bad++; $display("FAIL waw_popped got=%b exp=1", bus_if.lu_ready); end
    tick();
    drive(1'b1, 5'd12, 32'h33, 1'b1, 5'd12, 32'h44); expect_wr(5'd12, 32'h33);
    @(negedge clk);
    tick();
    idle();
    @(negedge clk);
    total++; if (bus_if.pend_valid !== 2'b00) begin bad++; $display("FAIL waw_pushkill got=%b exp=00", bus_if.pend_valid); end
    tick();
  endtask

  task automatic test_x0();
    drive(1'b1, 5'd3, 32'hD0, 1'b1, 5'd0, 32'h55); expect_wr(5'd3, 32'hD0);
    @(negedge clk);
    total++; if (bus_if.lu_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b exp=1", bus_if.lu_ready); end
    tick();
    drive(1'b1, 5'd0, 32'h99, 1'b1, 5'd4, 32'h66); expect_wr(5'd4, 32'h66);
    @(negedge clk);
    total++; if (bus_if.pend_valid !== 2'b00) begin bad++; $display("FAIL x0_count got=%b exp=00", bus_if.pend_valid); end
    tick();
    idle();
    @(negedge clk);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd3, 32'hE0, 1'b1, 5'd10, 32'hA); expect_wr(5'd3, 32'hE0);
    @(negedge clk); tick();
    drive(1'b1, 5'd3, 32'hE1, 1'b1, 5'd11, 32'hB); expect_wr(5'd3, 32'hE1);
    @(negedge clk); tick();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 5'd3, 32'hE2 + 32'(k), 1'b0, 5'd0, 32'd0); expect_wr(5'd3, 32'hE2 + 32'(k));
      @(negedge clk); tick();
    end
    drive(1'b1, 5'd3, 32'hEF, 1'b0, 5'd0, 32'd0); expect_wr(5'd3, 32'hEF);
    @(negedge clk);
    total++; if (bus_if.bubble_req !== 1'b1 || bus_if.lu_ready !== 1'b0 || bus_if.pend_valid !== 2'b11) begin bad++; $display("FAIL rmid_pre got=%b/%b/%b exp=1/0/11", bus_if.bubble_req, bus_if.lu_ready, bus_if.pend_valid); end
    tick();
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC);
    @(negedge clk);
    total++; if (bus_if.rf_we !== 1'b0) begin bad++; $display("FAIL rmid_we got=%b exp=0", bus_if.rf_we); end
    tick();
    reset = 1'b0;
    idle();
    @(negedge clk);
    total++; if (bus_if.lu_ready !== 1'b1 || bus_if.bubble_req !== 1'b0) begin bad++; $display("FAIL rmid_post got=%b/%b exp=1/0", bus_if.lu_ready, bus_if.bubble_req); end
    total++; if (bus_if.pend_valid !== 2'b00 || bus_if.pend_rd0 !== 5'd0 || bus_if.pend_rd1 !== 5'd0) begin bad++; $display("FAIL rmid_pend got=%b/%0d/%0d exp=00/0/0", bus_if.pend_valid, bus_if.pend_rd0, bus_if.pend_rd1); end
    tick();
    idle();
    @(negedge clk);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_bypass();
    test_contention();
    test_starvation();
    test_waw();
    test_x0();
    test_reset_mid();
    @(negedge clk);
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
